// File: rtl/lc2k_multicycle.sv
`default_nettype none
// ============================================================================
// Module   : lc2k_multicycle
// Purpose  : Multicycle LC2K core (8-opcode ISA) with one unified memory port
//            using a req/ready handshake. The control FSM is
//            FETCH -> DECODE -> EXEC -> (MEM) -> (WB) -> FETCH, plus a
//            terminal HALT state.
// Ports    : CLK, RST (sync, active-low), EN (run enable, sampled in FETCH)
//            mem_req/mem_we/mem_addr/mem_wdata  - registered request outputs
//            mem_rdata/mem_ready                - response, transfer on req&ready
//            pc, halted, instr_count            - status
// Revision : 1.0 - initial release
// ============================================================================
module lc2k_multicycle #(
  parameter int                DATA_W   = 32,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic [31:0]       instr_count
);

  localparam logic [2:0] c_FETCH  = 3'd0;
  localparam logic [2:0] c_DECODE = 3'd1;
  localparam logic [2:0] c_EXEC   = 3'd2;
  localparam logic [2:0] c_MEM    = 3'd3;
  localparam logic [2:0] c_WB     = 3'd4;
  localparam logic [2:0] c_HALT   = 3'd5;

  localparam logic [2:0] c_OP_ADD  = 3'd0;
  localparam logic [2:0] c_OP_NOR  = 3'd1;
  localparam logic [2:0] c_OP_LW   = 3'd2;
  localparam logic [2:0] c_OP_SW   = 3'd3;
  localparam logic [2:0] c_OP_BEQ  = 3'd4;
  localparam logic [2:0] c_OP_JALR = 3'd5;
  localparam logic [2:0] c_OP_HALT = 3'd6;

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  // Only IR[24:0] is ever decoded, so the upper fetched bits are not kept.
  logic [24:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, alu_q, alu_d, mdr_q, mdr_d;
  logic [DATA_W-1:0] rf_q [8];
  logic [31:0]       cnt_q, cnt_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  logic [2:0]        w_op, w_ra, w_rb, w_dst;
  logic [DATA_W-1:0] w_off, w_pc1_ext, w_rf_wdata;
  logic [ADDR_W-1:0] w_pc1;
  logic              w_hs, w_retire, w_rf_we;
  logic [2:0]        w_rf_waddr;

  always_comb begin
    w_op      = ir_q[24:22];
    w_ra      = ir_q[21:19];
    w_rb      = ir_q[18:16];
    w_dst     = ir_q[2:0];
    w_off     = {{(DATA_W-16){ir_q[15]}}, ir_q[15:0]};
    w_pc1     = pc_q + ADDR_W'(1);
    w_pc1_ext = '0;
    w_pc1_ext[ADDR_W-1:0] = w_pc1;
    w_hs      = req_q & mem_ready;
  end

  // Control FSM and datapath next-state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    a_d        = a_q;
    b_d        = b_q;
    alu_d      = alu_q;
    mdr_d      = mdr_q;
    w_retire   = 1'b0;
    w_rf_we    = 1'b0;
    w_rf_waddr = 3'd0;
    w_rf_wdata = '0;
    case (state_q)
      c_FETCH: begin
        if (w_hs) begin
          ir_d    = mem_rdata[24:0];
          state_d = c_DECODE;
        end
      end
      c_DECODE: begin
        a_d = rf_q[w_ra];
        b_d = rf_q[w_rb];
        if (w_op == c_OP_HALT) begin
          state_d  = c_HALT;
          w_retire = 1'b1;
        end else begin
          state_d = c_EXEC;
        end
      end
      c_EXEC: begin
        case (w_op)
          c_OP_ADD: begin
            alu_d   = a_q + b_q;
            state_d = c_WB;
          end
          c_OP_NOR: begin
            alu_d   = ~(a_q | b_q);
            state_d = c_WB;
          end
          c_OP_LW, c_OP_SW: begin
            alu_d   = a_q + w_off;
            state_d = c_MEM;
          end
          c_OP_BEQ: begin
            pc_d     = (a_q == b_q) ? (w_pc1 + w_off[ADDR_W-1:0]) : w_pc1;
            w_retire = 1'b1;
            state_d  = c_FETCH;
          end
          c_OP_JALR: begin
            w_rf_we    = 1'b1;
            w_rf_waddr = w_rb;
            w_rf_wdata = w_pc1_ext;
            // A was read before the link write, so regA==regB falls through.
            pc_d       = (w_ra == w_rb) ? w_pc1 : a_q[ADDR_W-1:0];
            w_retire   = 1'b1;
            state_d    = c_FETCH;
          end
          default: begin
            // noop (halt never reaches EXEC)
            pc_d     = w_pc1;
            w_retire = 1'b1;
            state_d  = c_FETCH;
          end
        endcase
      end
      c_MEM: begin
        if (w_hs) begin
          if (w_op == c_OP_SW) begin
            pc_d     = w_pc1;
            w_retire = 1'b1;
            state_d  = c_FETCH;
          end else begin
            mdr_d   = mem_rdata;
            state_d = c_WB;
          end
        end
      end
      c_WB: begin
        w_rf_we = 1'b1;
        if (w_op == c_OP_LW) begin
          w_rf_waddr = w_rb;
          w_rf_wdata = mdr_q;
        end else begin
          w_rf_waddr = w_dst;
          w_rf_wdata = alu_q;
        end
        pc_d     = w_pc1;
        w_retire = 1'b1;
        state_d  = c_FETCH;
      end
      c_HALT: begin
      end
      default: state_d = c_FETCH;
    endcase
    cnt_d = w_retire ? (cnt_q + 32'd1) : cnt_q;
  end

  // Memory port outputs are registered from the next state, so a request is
  // live in the first cycle of FETCH/MEM and holds steady while stalled
  // (pc/ALU/B do not change until the handshake).
  always_comb begin
    req_d   = 1'b0;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_d)
      c_FETCH: begin
        req_d  = EN;
        addr_d = pc_d;
      end
      c_MEM: begin
        req_d   = 1'b1;
        we_d    = (w_op == c_OP_SW);
        addr_d  = alu_d[ADDR_W-1:0];
        wdata_d = b_q;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= c_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      alu_q   <= '0;
      mdr_q   <= '0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      alu_q   <= alu_d;
      mdr_q   <= mdr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (w_rf_we) rf_q[w_rf_waddr] <= w_rf_wdata;
    end
  end

  assign mem_req     = req_q;
  assign mem_we      = we_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign pc          = pc_q;
  assign halted      = (state_q == c_HALT);
  assign instr_count = cnt_q;

endmodule
`default_nettype wire
